// File: rtl/pi_mul_sequencer.sv
// rtl/pi_mul_sequencer.sv - sequential PI stage driving an external signed multiplier
//
// Integrates the error sample, then computes
//   out = sat_OUT((cp*err + ci*integral) >>> FRAC)
// using two passes of an external sequential multiplier (level arm/fin handshake).
//
// Ports:
//   clk      - clock, all state on rising edge
//   rst_L    - asynchronous active-low reset
//   arm      - level request: high starts, low aborts or acknowledges done
//   int_clr  - zeroes the integrator (IDLE only, wins over arm)
//   err      - signed error sample, latched in IDLE
//   cp, ci   - signed proportional / integral coefficients, latched with err
//   mul_arm  - multiplier arm (level)
//   mul_a1   - multiplier operand 1 (coefficient)
//   mul_a2   - multiplier operand 2 (error or integrator)
//   mul_prod - signed multiplier product
//   mul_fin  - multiplier done (level, clears while mul_arm is low)
//   out      - signed saturated result, registered
//   busy     - high while a computation is in flight
//   done     - high while the result is being presented

module pi_mul_sequencer #(
   parameter int ERR_WID  = 12,
   parameter int INT_WID  = 16,
   parameter int COEF_WID = 16,
   parameter int FRAC     = 8,
   parameter int OUT_WID  = 12
) (
   input  logic                         clk,
   input  logic                         rst_L,
   input  logic                         arm,
   input  logic                         int_clr,
   input  logic [ERR_WID-1:0]           err,
   input  logic [COEF_WID-1:0]          cp,
   input  logic [COEF_WID-1:0]          ci,
   output logic                         mul_arm,
   output logic [COEF_WID-1:0]          mul_a1,
   output logic [INT_WID-1:0]           mul_a2,
   input  logic [COEF_WID+INT_WID-1:0]  mul_prod,
   input  logic                         mul_fin,
   output logic [OUT_WID-1:0]           out,
   output logic                         busy,
   output logic                         done
);

   localparam int PW = COEF_WID + INT_WID;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_P,
      S_GAP,
      S_MUL_I,
      S_SUM,
      S_DONE
   } state_t;

   state_t                state_q;
   logic [INT_WID-1:0]    integral_q;
   logic [COEF_WID-1:0]   ci_q;
   logic [PW-1:0]         prod_p_q;
   logic [PW-1:0]         prod_i_q;
   logic [OUT_WID-1:0]    out_q;
   logic                  mul_arm_q;
   logic [COEF_WID-1:0]   mul_a1_q;
   logic [INT_WID-1:0]    mul_a2_q;
   logic                  busy_q;
   logic                  done_q;

   logic [INT_WID-1:0]    err_ext;
   logic signed [INT_WID:0] int_sum;
   logic [INT_WID-1:0]    integral_d;
   logic signed [PW:0]    sum_pi;
   logic signed [PW:0]    sum_sh;
   logic [PW-OUT_WID+1:0] sh_hi;
   logic [OUT_WID-1:0]    out_d;

   assign err_ext = INT_WID'($signed(err));

   always_comb begin
      // Integrator update one bit wider, then clamp if the top two bits disagree.
      int_sum = $signed({integral_q[INT_WID-1], integral_q}) + $signed((INT_WID+1)'($signed(err)));
      integral_d = int_sum[INT_WID-1:0];
      if (int_sum[INT_WID] != int_sum[INT_WID-1]) begin
         integral_d = int_sum[INT_WID] ? {1'b1, {(INT_WID-1){1'b0}}}
                                       : {1'b0, {(INT_WID-1){1'b1}}};
      end

      // Arithmetic shift floors toward -inf; the value fits OUT_WID when all
      // bits from the output sign bit upward are identical.
      sum_pi = $signed({prod_p_q[PW-1], prod_p_q}) + $signed({prod_i_q[PW-1], prod_i_q});
      sum_sh = sum_pi >>> FRAC;
      sh_hi  = sum_sh[PW:OUT_WID-1];
      out_d  = sum_sh[OUT_WID-1:0];
      if (!((&sh_hi) || !(|sh_hi))) begin
         out_d = sh_hi[PW-OUT_WID+1] ? {1'b1, {(OUT_WID-1){1'b0}}}
                                     : {1'b0, {(OUT_WID-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state_q    <= S_IDLE;
         integral_q <= '0;
         ci_q       <= '0;
         prod_p_q   <= '0;
         prod_i_q   <= '0;
         out_q      <= '0;
         mul_arm_q  <= 1'b0;
         mul_a1_q   <= '0;
         mul_a2_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (int_clr) begin
                  integral_q <= '0;
               end else if (arm) begin
                  // mul_a1/mul_a2 double as the latched cp and err for MUL_P.
                  ci_q       <= ci;
                  integral_q <= integral_d;
                  mul_a1_q   <= cp;
                  mul_a2_q   <= err_ext;
                  mul_arm_q  <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= S_MUL_P;
               end
            end

            S_MUL_P: begin
               if (!arm) begin
                  state_q   <= S_IDLE;
                  mul_arm_q <= 1'b0;
                  mul_a1_q  <= '0;
                  mul_a2_q  <= '0;
                  busy_q    <= 1'b0;
               end else if (mul_fin) begin
                  prod_p_q  <= mul_prod;
                  mul_arm_q <= 1'b0;
                  state_q   <= S_GAP;
               end
            end

            // One cycle with mul_arm low so the multiplier drops fin and re-initialises.
            S_GAP: begin
               if (!arm) begin
                  state_q  <= S_IDLE;
                  mul_a1_q <= '0;
                  mul_a2_q <= '0;
                  busy_q   <= 1'b0;
               end else begin
                  mul_a1_q  <= ci_q;
                  mul_a2_q  <= integral_q;
                  mul_arm_q <= 1'b1;
                  state_q   <= S_MUL_I;
               end
            end

            S_MUL_I: begin
               if (!arm) begin
                  state_q   <= S_IDLE;
                  mul_arm_q <= 1'b0;
                  mul_a1_q  <= '0;
                  mul_a2_q  <= '0;
                  busy_q    <= 1'b0;
               end else if (mul_fin) begin
                  prod_i_q  <= mul_prod;
                  mul_arm_q <= 1'b0;
                  mul_a1_q  <= '0;
                  mul_a2_q  <= '0;
                  state_q   <= S_SUM;
               end
            end

            S_SUM: begin
               busy_q <= 1'b0;
               if (!arm) begin
                  state_q <= S_IDLE;
               end else begin
                  out_q   <= out_d;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end

            S_DONE: begin
               if (!arm) begin
                  done_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end

            default: begin
               state_q   <= S_IDLE;
               mul_arm_q <= 1'b0;
               mul_a1_q  <= '0;
               mul_a2_q  <= '0;
               busy_q    <= 1'b0;
               done_q    <= 1'b0;
            end
         endcase
      end
   end

   assign mul_arm = mul_arm_q;
   assign mul_a1  = mul_a1_q;
   assign mul_a2  = mul_a2_q;
   assign out     = out_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_pi_mul_sequencer.sv
// tb/tb_pi_mul_sequencer.sv - randomized self-checking bench for pi_mul_sequencer

module tb_pi_mul_sequencer;

   localparam int LAT = 13;

   logic               clk;
   logic               rst_L;
   logic               arm;
   logic               int_clr;
   logic signed [11:0] err;
   logic signed [15:0] cp;
   logic signed [15:0] ci;
   logic               mul_arm;
   logic signed [15:0] mul_a1;
   logic signed [15:0] mul_a2;
   logic signed [31:0] mul_prod;
   logic               mul_fin;
   logic signed [11:0] out;
   logic               busy;
   logic               done;

   int n_chk;
   int n_pass;

   longint integ_m;
   longint out_m;

   pi_mul_sequencer dut (
      .clk      (clk),
      .rst_L    (rst_L),
      .arm      (arm),
      .int_clr  (int_clr),
      .err      (err),
      .cp       (cp),
      .ci       (ci),
      .mul_arm  (mul_arm),
      .mul_a1   (mul_a1),
      .mul_a2   (mul_a2),
      .mul_prod (mul_prod),
      .mul_fin  (mul_fin),
      .out      (out),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural multiplier: fin is sampled high 5 cycles after arm rises,
   // and drops on the first edge that sees arm low.
   int mul_cnt;
   always @(posedge clk) begin
      if (!mul_arm) begin
         mul_cnt  <= 0;
         mul_fin  <= 1'b0;
      end else begin
         mul_cnt <= mul_cnt + 1;
         if (mul_cnt == 3) begin
            mul_fin  <= 1'b1;
            mul_prod <= mul_a1 * mul_a2;
         end
      end
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic longint clampv(input longint v, input longint lo, input longint hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic longint floor_div256(input longint s);
      if (s >= 0) return s / 256;
      return -((-s + 255) / 256);
   endfunction

   function automatic longint dut_integral();
      return longint'($signed(dut.integral_q));
   endfunction

   task automatic run_sample(input int e, input int c_p, input int c_i, input string tag);
      int cyc;
      integ_m = clampv(integ_m + e, -32768, 32767);
      out_m   = clampv(floor_div256(longint'(c_p) * e + longint'(c_i) * integ_m), -2048, 2047);
      @(negedge clk);
      err = 12'(e);
      cp  = 16'(c_p);
      ci  = 16'(c_i);
      arm = 1'b1;
      cyc = 0;
      while (!done && cyc < 200) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (cyc == 1) begin
            check({tag, " p_arm"}, longint'(mul_arm), 1);
            check({tag, " p_a1"}, longint'(mul_a1), longint'(c_p));
            check({tag, " p_a2"}, longint'(mul_a2), longint'(e));
            check({tag, " busy"}, longint'(busy), 1);
            err = 12'($urandom);
            cp  = 16'($urandom);
            ci  = 16'($urandom);
         end
      end
      check({tag, " latency"}, longint'(cyc), LAT);
      check({tag, " out"}, longint'(out), out_m);
      check({tag, " integral"}, dut_integral(), integ_m);
      arm = 1'b0;
      @(negedge clk);
      check({tag, " done_clr"}, longint'(done), 0);
   endtask

   task automatic clear_integral();
      @(negedge clk);
      int_clr = 1'b1;
      @(negedge clk);
      int_clr = 1'b0;
      integ_m = 0;
   endtask

   initial begin
      logic seen_done;
      longint out_before;
      n_chk   = 0;
      n_pass  = 0;
      integ_m = 0;
      out_m   = 0;
      rst_L   = 1'b0;
      arm     = 1'b0;
      int_clr = 1'b0;
      err     = '0;
      cp      = '0;
      ci      = '0;
      repeat (3) @(negedge clk);
      check("rst out", longint'(out), 0);
      check("rst busy", longint'(busy), 0);
      check("rst done", longint'(done), 0);
      check("rst mul_arm", longint'(mul_arm), 0);
      check("rst mul_a1", longint'(mul_a1), 0);
      check("rst mul_a2", longint'(mul_a2), 0);
      rst_L = 1'b1;

      // Proportional only, unity gain.
      run_sample(100, 256, 0, "t1");

      // Integral only, half gain, two successive samples.
      clear_integral();
      run_sample(10, 0, 128, "t2a");
      run_sample(10, 0, 128, "t2b");

      // Floor rounding of negative results.
      clear_integral();
      run_sample(-3, 128, 0, "t3a");
      run_sample(3, 128, 0, "t3b");

      // Output saturation both ways.
      run_sample(2047, 32767, 0, "t4a");
      run_sample(-2048, 32767, 0, "t4b");

      // Integrator saturation at the positive rail.
      for (int i = 0; i < 20; i++)
         run_sample(2047, int'($urandom_range(0, 65535)) - 32768, 0, "t4sat");

      // Random operands across the full ranges.
      clear_integral();
      for (int i = 0; i < 30; i++)
         run_sample(int'($urandom_range(0, 4095)) - 2048,
                    int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 65535)) - 32768, "rnd");

      // Abort in the middle of the integral multiply.
      out_before = longint'(out);
      integ_m = clampv(integ_m + 50, -32768, 32767);
      @(negedge clk);
      err = 12'sd50;
      cp  = 16'sd256;
      ci  = 16'sd256;
      arm = 1'b1;
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("abort in_mul_i arm", longint'(mul_arm), 1);
      check("abort in_mul_i a1", longint'(mul_a1), 256);
      arm = 1'b0;
      @(negedge clk);
      check("abort mul_arm", longint'(mul_arm), 0);
      check("abort busy", longint'(busy), 0);
      seen_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check("abort no_done", longint'(seen_done), 0);
      check("abort out_held", longint'(out), out_before);
      check("abort integral", dut_integral(), integ_m);
      run_sample(-7, 300, -200, "post_abort");

      // Asynchronous reset in MUL_P.
      @(negedge clk);
      err = 12'sd5;
      cp  = 16'sd256;
      ci  = 16'sd0;
      arm = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst_L = 1'b0;
      #1;
      check("areset mul_arm", longint'(mul_arm), 0);
      check("areset busy", longint'(busy), 0);
      check("areset out", longint'(out), 0);
      check("areset mul_a1", longint'(mul_a1), 0);
      check("areset integral", dut_integral(), 0);
      integ_m = 0;
      arm = 1'b0;
      @(negedge clk);
      rst_L = 1'b1;

      // int_clr wins over arm in IDLE.
      run_sample(77, 256, 0, "pre_clr");
      @(negedge clk);
      int_clr = 1'b1;
      arm     = 1'b1;
      @(negedge clk);
      check("clr busy", longint'(busy), 0);
      check("clr mul_arm", longint'(mul_arm), 0);
      check("clr integral", dut_integral(), 0);
      int_clr = 1'b0;
      arm     = 1'b0;
      integ_m = 0;
      run_sample(20, 0, 256, "post_clr");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pi_mul_sequencer.md
Name: pi_mul_sequencer

Overview:
- Sequential PI (proportional-integral) arithmetic stage for the control loop.
- Integrates the error sample, then computes out = (cp*err + ci*integral) >>> FRAC, saturated to OUT_WID.
- Drives an external sequential signed multiplier twice per sample through that multiplier's level arm/fin handshake, and consumes its product output.
- Upstream, the loop controller holds arm high with a stable error sample.

Parameters:
ERR_WID, 12, signed error sample width
INT_WID, 16, signed integrator width; also the multiplier a2 width; must be at least ERR_WID
COEF_WID, 16, signed coefficient width; also the multiplier a1 width
FRAC, 8, fractional bits of cp/ci; the product is shifted right arithmetically by FRAC
OUT_WID, 12, signed output width

Ports:
clk  in  1  clock; all state on rising edge
rst_L  in  1  asynchronous active-low reset
arm  in  1  level request; high starts a computation, low aborts or acknowledges
int_clr  in  1  zeroes the integrator; sampled only in IDLE
err  in  ERR_WID  signed error, sampled in IDLE when arm is high
cp  in  COEF_WID  signed proportional coefficient, sampled with err
ci  in  COEF_WID  signed integral coefficient, sampled with err
mul_arm  out  1  multiplier arm (level)
mul_a1  out  COEF_WID  multiplier operand 1 (coefficient)
mul_a2  out  INT_WID  multiplier operand 2 (error or integrator)
mul_prod  in  COEF_WID+INT_WID  signed multiplier product
mul_fin  in  1  multiplier done (level; clears when mul_arm is low)
out  out  OUT_WID  signed saturated result, registered
busy  out  1  high in MUL_P, GAP, MUL_I and SUM
done  out  1  high in DONE

Behaviour:
- Reset (asynchronous): state=IDLE; integral, latched operands, products and out are 0; mul_arm, busy and done are 0.
- IDLE: if int_clr is high, integral<=0 (int_clr takes priority over arm that cycle; the state stays IDLE). Otherwise, if arm is high:
  - latch cp and ci;
  - latch err sign-extended to INT_WID;
  - integral <= sat_INT(integral + err), computed at INT_WID+1 bits, clamped to [-2^(INT_WID-1), 2^(INT_WID-1)-1];
  - go to MUL_P.
- MUL_P: mul_arm=1, mul_a1=cp_l, mul_a2=err_ext. In the first cycle where mul_fin=1: prod_p<=mul_prod, go to GAP.
- GAP: exactly 1 cycle with mul_arm=0, so the multiplier re-initialises. Go to MUL_I.
- MUL_I: mul_arm=1, mul_a1=ci_l, mul_a2=integral (the updated value). On mul_fin=1: prod_i<=mul_prod, go to SUM.
  - A mul_fin still high from the previous run is impossible, because GAP guarantees at least one low cycle.
- SUM: 1 cycle.
  - s = prod_p + prod_i at COEF_WID+INT_WID+1 bits.
  - q = s >>> FRAC (floor, rounds toward negative infinity).
  - out <= q clamped to [-2^(OUT_WID-1), 2^(OUT_WID-1)-1].
  - Go to DONE.
- DONE: done=1, out holds. When arm goes low, go to IDLE; done=0 from the next cycle.
- out changes only on the SUM→DONE transition or reset.
- Latency: let Lp and Li be the cycles from mul_arm rising until mul_fin is sampled high. Then done rises 1 (IDLE) + Lp + 1 (GAP) + Li + 1 (SUM) cycles after arm is sampled high.
- Abort: arm low in MUL_P, GAP, MUL_I or SUM → IDLE on the next edge.
  - mul_arm goes low and done stays 0.
  - out is unchanged.
  - The integral update already made is kept, not rolled back.
- mul_a1 and mul_a2 are held stable for the whole time mul_arm is high; they are 0 in IDLE.
- err, cp and ci may change freely after IDLE; only the latched copies are used.
- No combinational path from any input to any output.

Test Plan:
Bench uses default parameters and a behavioural signed multiplier with fin 5 cycles after arm.
1. cp=256 (1.0), ci=0, err=100 → out=100, done high 13 cycles after arm, integral=100.
2. cp=0, ci=128 (0.5), err=10 on two successive samples (arm lowered between them) → integral 10 then 20; out=5 then 10.
3. cp=128, ci=0, err=-3 → out=-2 (floor of -1.5); err=3 → out=1.
4. Saturation:
   - cp=32767, err=2047 → out=2047; err=-2048 → out=-2048.
   - ci=0, err=2047 for 20 samples → integral clamps at 32767 and never wraps negative.
5. Abort: drop arm during MUL_I → mul_arm=0 on the next cycle, busy=0, done never rises, out unchanged, integral incremented once; the next arm computes normally.
6. Reset and clear:
   - Assert rst_L low asynchronously mid MUL_P → all outputs 0 immediately, without waiting for a clock edge; integral=0.
   - int_clr=1 together with arm=1 in IDLE → integral=0 and no computation starts.
